// File: rtl/tdc_pkg.sv
// Shared types for the TDC thermometer decoder: state encoding, result bundle.
// Optional bubble correction is enabled with TDC_BUBBLE_CORR_EN.
package tdc_pkg;

   localparam int N_DELAY_DEF = 32;
   localparam int CNT_MAX_W   = 16;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      DECODE,
      ACCUM,
      OUT
   } state_t;

   // count is sized for the widest supported chain; users slice to CNT_W
   typedef struct packed {
      logic [CNT_MAX_W-1:0] count;
      logic                 underflow;
      logic                 overflow;
   } result_t;

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-binary encoder with optional bubble filter.
// Define TDC_BUBBLE_CORR_EN to enable the 3-tap majority filter.
module tdc_therm2bin
   import tdc_pkg::*;
#(
   parameter int N_DELAY = N_DELAY_DEF
) (
   input  logic [N_DELAY-1:0] therm,
   output result_t            res
);

   logic [N_DELAY-1:0] filt;

`ifdef TDC_BUBBLE_CORR_EN
   always_comb begin
      filt            = '0;
      filt[0]         = therm[0] & therm[1];
      filt[N_DELAY-1] = therm[N_DELAY-2] & therm[N_DELAY-1];
      for (int i = 1; i < N_DELAY - 1; i++) begin
         filt[i] = (therm[i-1] & therm[i])
                 | (therm[i-1] & therm[i+1])
                 | (therm[i] & therm[i+1]);
      end
   end
`else
   assign filt = therm;
`endif

   // count is the index of the lowest zero; all-ones reads as N_DELAY
   always_comb begin
      res       = '0;
      res.count = CNT_MAX_W'(N_DELAY);
      for (int i = N_DELAY - 1; i >= 0; i--) begin
         if (!filt[i]) begin
            res.count = CNT_MAX_W'(i);
         end
      end
      res.underflow = (filt == '0);
      res.overflow  = &filt;
   end

endmodule

// File: rtl/tdc_therm_decoder.sv
// TDC stop synchroniser, thermometer decode, averaging and result handshake.
// Define TDC_BUBBLE_CORR_EN to enable bubble correction in the encoder.
module tdc_therm_decoder
   import tdc_pkg::*;
#(
   parameter  int N_DELAY     = N_DELAY_DEF,
   parameter  int AVG_LOG2    = 0,
   parameter  int SYNC_STAGES = 2,
   localparam int CNT_W       = cnt_w(N_DELAY)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stop_in,
   input  logic [N_DELAY-1:0] therm_in,
   output logic [CNT_W-1:0]   meas_data,
   output logic               meas_underflow,
   output logic               meas_overflow,
   output logic               meas_valid,
   input  logic               meas_ready,
   output logic               drop_flag
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int SC_W  = AVG_LOG2 + 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'((1 << AVG_LOG2) - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d;
   logic                   stop_evt;

   state_t state_q;
   state_t state_d;

   logic [N_DELAY-1:0] samp_q;
   result_t            res;
   logic [CNT_W-1:0]   cnt_q;
   logic               uf_q;
   logic               of_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_sum;
   logic [SC_W-1:0]    sc_q;
   logic               suf_q;
   logic               sof_q;
   logic               last;

   tdc_therm2bin #(
      .N_DELAY(N_DELAY)
   ) u_t2b (
      .therm(samp_q),
      .res  (res)
   );

   generate
      if (CNT_W < CNT_MAX_W) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^res.count[CNT_MAX_W-1:CNT_W];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], stop_in};
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign stop_evt = sync_q[SYNC_STAGES-1] & ~sync_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign acc_sum = acc_q + ACC_W'(cnt_q);
   assign last    = (sc_q == SC_LAST);

   always_comb begin
      state_d    = state_q;
      meas_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (stop_evt) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: state_d = DECODE;
         DECODE:  state_d = ACCUM;
         ACCUM:   state_d = last ? OUT : IDLE;
         OUT: begin
            meas_valid = 1'b1;
            if (meas_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q         <= '0;
         cnt_q          <= '0;
         uf_q           <= 1'b0;
         of_q           <= 1'b0;
         acc_q          <= '0;
         sc_q           <= '0;
         suf_q          <= 1'b0;
         sof_q          <= 1'b0;
         meas_data      <= '0;
         meas_underflow <= 1'b0;
         meas_overflow  <= 1'b0;
         drop_flag      <= 1'b0;
      end else begin
         unique case (state_q)
            CAPTURE: samp_q <= therm_in;
            DECODE: begin
               cnt_q <= res.count[CNT_W-1:0];
               uf_q  <= res.underflow;
               of_q  <= res.overflow;
            end
            ACCUM: begin
               if (last) begin
                  meas_data      <= CNT_W'(acc_sum >> AVG_LOG2);
                  meas_underflow <= suf_q | uf_q;
                  meas_overflow  <= sof_q | of_q;
                  acc_q          <= '0;
                  sc_q           <= '0;
                  suf_q          <= 1'b0;
                  sof_q          <= 1'b0;
               end else begin
                  acc_q <= acc_sum;
                  sc_q  <= sc_q + SC_W'(1);
                  suf_q <= suf_q | uf_q;
                  sof_q <= sof_q | of_q;
               end
            end
            default: ;
         endcase
         // any event outside IDLE, including the OUT handshake cycle, is lost
         if (stop_evt && (state_q != IDLE)) begin
            drop_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: AVG_LOG2=0 and AVG_LOG2=2 side by side.
// Reference decode honours TDC_BUBBLE_CORR_EN when defined.
module tb_tdc_therm_decoder;
   import tdc_pkg::*;

   localparam int N = 32;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         stop_in;
   logic         ready;
   logic [N-1:0] therm;

   logic [W-1:0] d0, d2;
   logic         uf0, of0, v0, df0;
   logic         uf2, of2, v2, df2;

   typedef struct {
      int data;
      bit uf;
      bit of;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   int   part_sum;
   int   part_n;
   bit   part_uf;
   bit   part_of;

   int checks   = 0;
   int failures = 0;

   bit           hold[2];
   logic [W-1:0] hd[2];
   logic         huf[2];
   logic         hof[2];
   bit           lat_arm;
   int           lat_cnt;

   always #5 clk = ~clk;

   tdc_therm_decoder #(
      .N_DELAY(N), .AVG_LOG2(0), .SYNC_STAGES(2)
   ) u0 (
      .clk(clk), .rst(rst), .stop_in(stop_in), .therm_in(therm),
      .meas_data(d0), .meas_underflow(uf0), .meas_overflow(of0),
      .meas_valid(v0), .meas_ready(ready), .drop_flag(df0)
   );

   tdc_therm_decoder #(
      .N_DELAY(N), .AVG_LOG2(2), .SYNC_STAGES(2)
   ) u2 (
      .clk(clk), .rst(rst), .stop_in(stop_in), .therm_in(therm),
      .meas_data(d2), .meas_underflow(uf2), .meas_overflow(of2),
      .meas_valid(v2), .meas_ready(ready), .drop_flag(df2)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [N-1:0] filt(input logic [N-1:0] w);
`ifdef TDC_BUBBLE_CORR_EN
      logic [N-1:0] f;
      f[0]   = w[0] & w[1];
      f[N-1] = w[N-2] & w[N-1];
      for (int i = 1; i < N - 1; i++) begin
         f[i] = (int'(w[i-1]) + int'(w[i]) + int'(w[i+1])) >= 2;
      end
      return f;
`else
      return w;
`endif
   endfunction

   function automatic exp_t ref_model(input logic [N-1:0] w);
      exp_t         e;
      logic [N-1:0] f;
      int           c;
      f = filt(w);
      c = 0;
      while (c < N && f[c]) c++;
      e.data = c;
      e.uf   = (f == '0);
      e.of   = (f == '1);
      return e;
   endfunction

   function automatic logic [N-1:0] therm_of(input int k);
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < k; i++) w[i] = 1'b1;
      return w;
   endfunction

   function automatic logic [N-1:0] rand_word();
      logic [N-1:0] w;
      int           r;
      w = therm_of($urandom_range(0, N));
      r = $urandom_range(0, 7);
      if (r < 2) w[$urandom_range(0, N - 1)] ^= 1'b1;
      else if (r == 2) w = $urandom;
      return w;
   endfunction

   task automatic model_push(input logic [N-1:0] w);
      exp_t e;
      exp_t g;
      e = ref_model(w);
      q0.push_back(e);
      part_sum += e.data;
      part_uf  |= e.uf;
      part_of  |= e.of;
      part_n++;
      if (part_n == 4) begin
         g.data = part_sum / 4;
         g.uf   = part_uf;
         g.of   = part_of;
         q2.push_back(g);
         part_sum = 0;
         part_n   = 0;
         part_uf  = 0;
         part_of  = 0;
      end
   endtask

   task automatic pulse_stop();
      @(posedge clk);
      #1 stop_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 stop_in = 1'b0;
   endtask

   task automatic sample(input logic [N-1:0] w, input bit rnd_ready);
      @(posedge clk);
      #1 therm = w;
      model_push(w);
      pulse_stop();
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1 ready = (rnd_ready && i < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic mon(input int k, input logic v, input logic [W-1:0] d,
                      input logic uf, input logic of);
      exp_t e;
      int   qs;
      if (hold[k]) begin
         chk($sformatf("hold%0d", k), int'({v, d, uf, of}),
             int'({1'b1, hd[k], huf[k], hof[k]}));
      end
      hold[k] = v && !ready;
      hd[k]   = d;
      huf[k]  = uf;
      hof[k]  = of;
      if (v && ready) begin
         qs = (k == 0) ? q0.size() : q2.size();
         if (qs == 0) begin
            checks++;
            failures++;
            $display("FAIL extra%0d actual=valid data=%0d required=no result", k, d);
         end else begin
            if (k == 0) e = q0.pop_front();
            else e = q2.pop_front();
            chk($sformatf("data%0d", k), int'(d), e.data);
            chk($sformatf("uf%0d", k), int'(uf), int'(e.uf));
            chk($sformatf("of%0d", k), int'(of), int'(e.of));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         hold[0] = 0;
         hold[1] = 0;
         lat_arm = 0;
      end else begin
         mon(0, v0, d0, uf0, of0);
         mon(1, v2, d2, uf2, of2);
         if (lat_arm) begin
            lat_cnt++;
            if (v0) begin
               chk("lat", lat_cnt, 3);
               lat_arm = 0;
            end
         end
         if (u0.stop_evt && u0.state_q == IDLE) begin
            lat_arm = 1;
            lat_cnt = -1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk_idle(input string tag, input int df);
      chk({tag, "_v0"}, int'(v0), 0);
      chk({tag, "_v2"}, int'(v2), 0);
      chk({tag, "_df0"}, int'(df0), df);
      chk({tag, "_df2"}, int'(df2), df);
   endtask

   initial begin
      rst      = 1'b1;
      stop_in  = 1'b0;
      ready    = 1'b1;
      therm    = '0;
      part_sum = 0;
      part_n   = 0;
      part_uf  = 0;
      part_of  = 0;
      repeat (3) @(negedge clk);
      chk_idle("rst", 0);
      chk("rst_d0", int'({d0, uf0, of0}), 0);
      chk("rst_d2", int'({d2, uf2, of2}), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      sample(32'h0000_00FF, 0);
      sample(32'h0000_0000, 0);
      sample(32'hFFFF_FFFF, 0);
      sample(32'h0000_00F7, 0);
      sample(therm_of(10), 0);
      sample(therm_of(11), 0);
      sample(therm_of(12), 0);
      sample(therm_of(14), 0);
      repeat (40) sample(rand_word(), 1);
      @(negedge clk);
      chk_idle("run", 0);

      repeat (3) sample(rand_word(), 0);
      @(posedge clk);
      #1 ready = 1'b0;
      therm = rand_word();
      model_push(therm);
      pulse_stop();
      repeat (10) @(posedge clk);
      pulse_stop();
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("drop_v0", int'(v0), 1);
      chk("drop_v2", int'(v2), 1);
      chk("drop_df0", int'(df0), 1);
      chk("drop_df2", int'(df2), 1);
      @(posedge clk);
      #1 ready = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk_idle("after_drop", 1);
      chk("q0_drop", q0.size(), 0);
      chk("q2_drop", q2.size(), 0);

      repeat (2) sample(rand_word(), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      part_sum = 0;
      part_n   = 0;
      part_uf  = 0;
      part_of  = 0;
      repeat (2) @(negedge clk);
      chk_idle("midrst", 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) sample(therm_of(5), 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("q0_end", q0.size(), 0);
      chk("q2_end", q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
